alarm_ringer: RTL and testbench

- Downstream stage of the alarm counter. It consumes that counter's beeb level and turns it into a pulsed buzzer drive.
- The buzzer pattern is ON_CYCLES high, then OFF_CYCLES low, repeated for up to MAX_BURSTS bursts.
- User controls: stop (acknowledge) and snooze.
- Status outputs: ringing, burst count and a one-cycle timeout pulse when the alarm gives up unanswered.

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_ringer_if.sv | 23 ++
 rtl/alarm_ringer_timer.sv | 27 ++
 rtl/alarm_ringer.sv | 159 +++++++++++++++
 tb/tb_alarm_ringer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared state encodings and default timing constants for the alarm counter
// and the alarm ringer.
package alarm_pkg;

  typedef logic [1:0] ring_state_t;

  localparam ring_state_t S_IDLE   = 2'd0;
  localparam ring_state_t S_ON     = 2'd1;
  localparam ring_state_t S_OFF    = 2'd2;
  localparam ring_state_t S_SNOOZE = 2'd3;

  localparam int DEF_ON_CYCLES     = 4;
  localparam int DEF_OFF_CYCLES    = 4;
  localparam int DEF_MAX_BURSTS    = 8;
  localparam int DEF_SNOOZE_CYCLES = 16;
  localparam int DEF_MAX_SNOOZES   = 3;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/alarm_ringer_if.sv
// User-control and status bundle between the alarm ringer and its surroundings.
// BC_W must equal $clog2(MAX_BURSTS+1) of the attached ringer.
interface alarm_ringer_if #(
  parameter int BC_W = 4
);
  logic            trigger;
  logic            stop;
  logic            snooze;
  logic            buzzer;
  logic            ringing;
  logic [BC_W-1:0] burst_count;
  logic            timed_out;

  modport master (
    output trigger, stop, snooze,
    input  buzzer, ringing, burst_count, timed_out
  );

  modport slave (
    input  trigger, stop, snooze,
    output buzzer, ringing, burst_count, timed_out
  );
endinterface

// File: rtl/alarm_ringer_timer.sv
// Loadable down-counter that parks at zero; times the ON, OFF and SNOOZE phases.
module alarm_ringer_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // A load always wins so a phase reload on the expiry cycle never underflows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_ringer.sv
// Turns the alarm counter's trigger level into a pulsed buzzer with stop/snooze.
// Optional: define ALARM_RINGER_SNOOZE_LIMIT_EN to cap snoozes per episode at MAX_SNOOZES.
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter int ON_CYCLES     = DEF_ON_CYCLES,
  parameter int OFF_CYCLES    = DEF_OFF_CYCLES,
  parameter int MAX_BURSTS    = DEF_MAX_BURSTS,
  parameter int SNOOZE_CYCLES = DEF_SNOOZE_CYCLES,
  parameter int MAX_SNOOZES   = DEF_MAX_SNOOZES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic           clock,
  input  logic           reset,
  alarm_ringer_if.slave  bus
);

  localparam int BC_W = $clog2(MAX_BURSTS + 1);
  localparam logic [CNT_W-1:0] ON_LOAD     = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_CYCLES - 1);

  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || MAX_BURSTS < 1 || SNOOZE_CYCLES < 1 ||
      MAX_SNOOZES < 0 || (ON_CYCLES - 1) >= (1 << CNT_W) ||
      (OFF_CYCLES - 1) >= (1 << CNT_W) || (SNOOZE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_params
    $error("alarm_ringer: illegal parameter combination");
  end

  ring_state_t      state;
  ring_state_t      state_nxt;
  logic             trigger_d;
  logic             rise;
  logic             snooze_ok;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_zero;
  logic [BC_W-1:0]  burst_cnt;
  logic [BC_W-1:0]  burst_nxt;
  logic             last_burst;
  logic             timeout_nxt;
  logic             episode_start;
  logic             buzzer_q;
  logic             ringing_q;
  logic             timed_out_q;

  assign rise          = bus.trigger & ~trigger_d;
  assign last_burst    = (burst_cnt == BC_W'(MAX_BURSTS - 1));
  assign episode_start = (state == S_IDLE) && (state_nxt == S_ON);

  alarm_ringer_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

`ifdef ALARM_RINGER_SNOOZE_LIMIT_EN
  localparam int SC_W = $clog2(MAX_SNOOZES + 1);

  logic [SC_W-1:0] snooze_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snooze_cnt <= '0;
    end else if (episode_start) begin
      snooze_cnt <= '0;
    end else if (state != S_SNOOZE && state_nxt == S_SNOOZE) begin
      snooze_cnt <= snooze_cnt + 1'b1;
    end
  end

  assign snooze_ok = (snooze_cnt < SC_W'(MAX_SNOOZES));
`else
  assign snooze_ok = 1'b1;
`endif

  // Per-cycle priority: stop, then snooze, then phase expiry / trigger rise.
  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    timer_load  = 1'b0;
    timer_val   = '0;
    timeout_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise && !bus.stop) begin
          state_nxt  = S_ON;
          timer_load = 1'b1;
          timer_val  = ON_LOAD;
          burst_nxt  = '0;
        end
      end
      S_ON, S_OFF: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (bus.snooze && snooze_ok) begin
          state_nxt  = S_SNOOZE;
          timer_load = 1'b1;
          timer_val  = SNOOZE_LOAD;
        end else if (timer_zero) begin
          if (state == S_ON) begin
            state_nxt  = S_OFF;
            timer_load = 1'b1;
            timer_val  = OFF_LOAD;
          end else begin
            burst_nxt = burst_cnt + 1'b1;
            if (last_burst) begin
              state_nxt   = S_IDLE;
              timeout_nxt = 1'b1;
            end else begin
              state_nxt  = S_ON;
              timer_load = 1'b1;
              timer_val  = ON_LOAD;
            end
          end
        end
      end
      S_SNOOZE: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (timer_zero) begin
          state_nxt  = S_ON;
          timer_load = 1'b1;
          timer_val  = ON_LOAD;
          burst_nxt  = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      trigger_d   <= 1'b0;
      burst_cnt   <= '0;
      buzzer_q    <= 1'b0;
      ringing_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      trigger_d   <= bus.trigger;
      burst_cnt   <= burst_nxt;
      buzzer_q    <= (state_nxt == S_ON);
      ringing_q   <= (state_nxt != S_IDLE);
      timed_out_q <= timeout_nxt;
    end
  end

  assign bus.buzzer      = buzzer_q;
  assign bus.ringing     = ringing_q;
  assign bus.burst_count = burst_cnt;
  assign bus.timed_out   = timed_out_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer: stimulus queues expected outputs, a negedge
// monitor pops and compares them. Default parameters (4/4/8/16/3).
module tb_alarm_ringer;

  logic clock;
  logic reset;

  alarm_ringer_if #(.BC_W(4)) bus ();

  alarm_ringer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       buzzer;
    logic       ringing;
    logic [3:0] bc;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, then land 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic trig, input logic stp, input logic snz);
    bus.trigger = trig;
    bus.stop    = stp;
    bus.snooze  = snz;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic b, input logic r,
                             input logic [3:0] bc, input logic to);
    exp_t e;
    e.name    = name;
    e.buzzer  = b;
    e.ringing = r;
    e.bc      = bc;
    e.to      = to;
    exp_q.push_back(e);
  endtask

  // Cycle k of an undisturbed ring: 4 high, 4 low, burst_count = k/8.
  task automatic ringCycles(input int from_k, input int to_k);
    for (int k = from_k; k <= to_k; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("pattern", 1'((k % 8) < 4), 1'b1, 4'(k / 8), 1'b0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.buzzer, bus.ringing, bus.burst_count, bus.timed_out} !==
            {e.buzzer, e.ringing, e.bc, e.to}) begin
          errors++;
          $display("[TB] FAIL %s at %0t: got buzzer=%0b ringing=%0b burst_count=%0d timed_out=%0b, expected buzzer=%0b ringing=%0b burst_count=%0d timed_out=%0b",
                   e.name, $time, bus.buzzer, bus.ringing, bus.burst_count, bus.timed_out,
                   e.buzzer, e.ringing, e.bc, e.to);
        end
      end
    end
  end

  initial begin : stimulus
    reset       = 1'b1;
    bus.trigger = 1'b0;
    bus.stop    = 1'b0;
    bus.snooze  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_state", 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("idle", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("[TB] full ring to timeout");
    ringCycles(0, 63);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("timeout_pulse", 1'b0, 1'b0, 4'd8, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("timeout_once", 1'b0, 1'b0, 4'd8, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("idle_after_timeout", 1'b0, 1'b0, 4'd8, 1'b0);

    $display("[TB] stop in second burst");
    ringCycles(0, 9);
    applyStimulus(1'b1, 1'b1, 1'b0); checkOutput("stop_in_burst2", 1'b0, 1'b0, 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("stop_level_no_rise", 1'b0, 1'b0, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("stop_readback", 1'b0, 1'b0, 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("restart_clears_count", 1'b1, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkOutput("stop_again", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("idle", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("[TB] snooze in third burst");
    ringCycles(0, 16);
    applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("snooze_enter", 1'b0, 1'b1, 4'd2, 1'b0);
    for (int j = 1; j <= 15; j++) begin
      applyStimulus(1'b1, 1'b0, 1'(j == 6));
      checkOutput("snooze_silent", 1'b0, 1'b1, 4'd2, 1'b0);
    end
    for (int k = 0; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("snooze_resume", 1'(k < 4), 1'b1, 4'd0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0); checkOutput("stop_after_snooze", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("idle", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("[TB] stop with snooze");
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("ring_start", 1'b1, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1); checkOutput("stop_beats_snooze", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("stays_idle", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("[TB] snooze on final OFF expiry");
    ringCycles(0, 63);
    applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("snooze_final_off", 1'b0, 1'b1, 4'd7, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("no_timeout", 1'b0, 1'b1, 4'd7, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkOutput("stop_in_snooze", 1'b0, 1'b0, 4'd7, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("idle", 1'b0, 1'b0, 4'd7, 1'b0);

    $display("[TB] async reset mid-ON");
    ringCycles(0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    reset = 1'b1;
    checkOutput("async_reset", 1'b0, 1'b0, 4'd0, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("reset_held", 1'b0, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("restart_after_reset", 1'b1, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("restart_on", 1'b1, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0); checkOutput("stop", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("idle", 1'b0, 1'b0, 4'd0, 1'b0);

    $display("[TB] four snoozes in one episode");
    ringCycles(0, 0);
    for (int n = 1; n <= 3; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b1); checkOutput("snooze_n", 1'b0, 1'b1, 4'd0, 1'b0);
      for (int j = 1; j <= 15; j++) begin
        applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("snooze_n_silent", 1'b0, 1'b1, 4'd0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("snooze_n_resume", 1'b1, 1'b1, 4'd0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
`ifdef ALARM_RINGER_SNOOZE_LIMIT_EN
    checkOutput("fourth_snooze_ignored", 1'b1, 1'b1, 4'd0, 1'b0);
`else
    checkOutput("fourth_snooze_taken", 1'b0, 1'b1, 4'd0, 1'b0);
`endif
    applyStimulus(1'b1, 1'b1, 1'b0); checkOutput("final_stop", 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("final_idle", 1'b0, 1'b0, 4'd0, 1'b0);

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
